rc_frame_assembler: RTL and testbench

RC_FRAME_ASSEMBLER -- requirements
Module: rc_frame_assembler

---
 rtl/rc_frame_assembler.sv | 196 +++++++++++++++++++
 tb/tb_rc_frame_assembler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rc_frame_assembler.sv
// rc_frame_assembler: turns a stream of UART bytes into RC read/write requests.
// A frame is a command byte, a 4-byte little-endian address, a 4-byte
// little-endian data word (write frames only) and an XOR checksum byte.
// Bad commands, checksum failures and mid-frame stalls each raise a
// one-cycle error pulse and drop the frame.
module rc_frame_assembler #(
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  CMD_WRITE      = 8'hA5,
    parameter logic [7:0]  CMD_READ       = 8'h5A
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_write,
    output logic [31:0] req_address,
    output logic [31:0] req_data,
    output logic        err_cmd,
    output logic        err_checksum,
    output logic        err_timeout,
    output logic [15:0] frame_count
);

    // Idle counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        CSUM  = 3'd3,
        ISSUE = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       byte_idx;
    logic [CNT_W-1:0] idle_cnt;
    logic             is_write;
    logic [31:0]      addr_sr;
    logic [31:0]      data_sr;
    logic [7:0]       csum_acc;

    logic byte_fire;
    logic req_fire;
    logic in_frame;
    logic timeout_hit;
    logic cmd_bad;
    logic csum_bad;
    logic frame_abort;

    // Handshake and status decode straight from the state register.
    always_comb begin
        byte_ready  = (state != ISSUE);
        req_valid   = (state == ISSUE);
        byte_fire   = byte_valid && byte_ready;
        req_fire    = req_valid && req_ready;
        in_frame    = (state == ADDR) || (state == DATA) || (state == CSUM);
        // An accepted byte on the last idle cycle takes priority over the timeout.
        timeout_hit = in_frame && !byte_fire && (idle_cnt == IDLE_LAST);
        req_write   = is_write;
        req_address = addr_sr;
        req_data    = is_write ? data_sr : 32'h0;
    end

    // Next-state decode and error-event detection.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next  = state;
        cmd_bad     = 1'b0;
        csum_bad    = 1'b0;
        frame_abort = 1'b0;
        case (state)
            IDLE: begin
                if (byte_fire) begin
                    if (byte_data == CMD_WRITE || byte_data == CMD_READ) begin
                        state_next = ADDR;
                    end else begin
                        cmd_bad = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (byte_fire) begin
                    if (byte_idx == 2'd3) begin
                        state_next = is_write ? DATA : CSUM;
                    end
                end else if (timeout_hit) begin
                    state_next  = IDLE;
                    frame_abort = 1'b1;
                end
            end
            DATA: begin
                if (byte_fire) begin
                    if (byte_idx == 2'd3) begin
                        state_next = CSUM;
                    end
                end else if (timeout_hit) begin
                    state_next  = IDLE;
                    frame_abort = 1'b1;
                end
            end
            CSUM: begin
                if (byte_fire) begin
                    if (byte_data == csum_acc) begin
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                        csum_bad   = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_next  = IDLE;
                    frame_abort = 1'b1;
                end
            end
            ISSUE: begin
                if (req_fire) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register, frame assembly registers, counters and error pulses.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before this edge, independent of order.
        if (!rstn) begin
            state        <= IDLE;
            byte_idx     <= 2'd0;
            idle_cnt     <= '0;
            is_write     <= 1'b0;
            addr_sr      <= 32'h0;
            data_sr      <= 32'h0;
            csum_acc     <= 8'h0;
            frame_count  <= 16'h0;
            err_cmd      <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_next;
            err_cmd      <= cmd_bad;
            err_checksum <= csum_bad;
            err_timeout  <= frame_abort;

            if (state_next != state) begin
                byte_idx <= 2'd0;
            end else if (byte_fire && (state == ADDR || state == DATA)) begin
                byte_idx <= byte_idx + 2'd1;
            end

            if (!in_frame || byte_fire || state_next != state) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (byte_fire) begin
                case (state)
                    IDLE: begin
                        if (state_next == ADDR) begin
                            // Start clean so an aborted frame cannot leak bytes.
                            is_write <= (byte_data == CMD_WRITE);
                            csum_acc <= byte_data;
                            addr_sr  <= 32'h0;
                            data_sr  <= 32'h0;
                        end
                    end
                    ADDR: begin
                        addr_sr  <= {byte_data, addr_sr[31:8]};
                        csum_acc <= csum_acc ^ byte_data;
                    end
                    DATA: begin
                        data_sr  <= {byte_data, data_sr[31:8]};
                        csum_acc <= csum_acc ^ byte_data;
                    end
                    default: begin
                    end
                endcase
            end

            if (req_fire) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rc_frame_assembler.sv
// tb_rc_frame_assembler: directed checks of frame assembly, handshakes,
// error pulses, timeout boundary, reset during ISSUE and counter wrap.
module tb_rc_frame_assembler;

    logic        clk;
    logic        rstn;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_address;
    logic [31:0] req_data;
    logic        err_cmd;
    logic        err_checksum;
    logic        err_timeout;
    logic [15:0] frame_count;

    int total = 0;
    int bad   = 0;

    // Error pulse counters sampled on the falling edge.
    int n_cmd = 0;
    int n_csum = 0;
    int n_to = 0;
    int n_multi = 0;

    localparam logic [7:0] W_FRAME [10] = '{8'hA5, 8'h00, 8'h10, 8'h40, 8'h00,
                                           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hD7};
    localparam logic [7:0] R_FRAME [6]  = '{8'h5A, 8'h00, 8'h20, 8'h40, 8'h00, 8'h3A};
    localparam logic [7:0] R2_FRAME [6] = '{8'h5A, 8'h00, 8'h30, 8'h40, 8'h00, 8'h2A};

    rc_frame_assembler #(
        .TIMEOUT_CYCLES(16),
        .CMD_WRITE     (8'hA5),
        .CMD_READ      (8'h5A)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_address (req_address),
        .req_data    (req_data),
        .err_cmd     (err_cmd),
        .err_checksum(err_checksum),
        .err_timeout (err_timeout),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_cmd)      n_cmd++;
        if (err_checksum) n_csum++;
        if (err_timeout)  n_to++;
        if ((32'(err_cmd) + 32'(err_checksum) + 32'(err_timeout)) > 1) n_multi++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until accepted (bounded wait).
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            tick();
            n++;
        end
        check("byte_ready_wait", 32'(byte_ready), 32'd1);
        tick();
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    initial begin
        int first_to;
        int to_base;
        rstn       = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        req_ready  = 1'b0;
        tick();
        tick();
        rstn = 1'b1;

        // Reset state
        check("rst_req_valid",   32'(req_valid),    32'd0);
        check("rst_byte_ready",  32'(byte_ready),   32'd1);
        check("rst_frame_count", 32'(frame_count),  32'd0);
        check("rst_req_write",   32'(req_write),    32'd0);
        check("rst_req_address", req_address,       32'h0);
        check("rst_req_data",    req_data,          32'h0);
        check("rst_errs", {29'd0, err_cmd, err_checksum, err_timeout}, 32'd0);

        // Write frame, RC side ready
        req_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_byte(W_FRAME[i]);
        check("wr_req_valid",   32'(req_valid),   32'd1);
        check("wr_req_write",   32'(req_write),   32'd1);
        check("wr_req_address", req_address,      32'h00401000);
        check("wr_req_data",    req_data,         32'hDEADBEEF);
        check("wr_byte_ready",  32'(byte_ready),  32'd0);
        tick();
        check("wr_valid_one_cycle", 32'(req_valid),   32'd0);
        check("wr_frame_count",     32'(frame_count), 32'd1);

        // Read frame with RC side stalled for 5 cycles
        req_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(R_FRAME[i]);
        for (int c = 0; c < 6; c++) begin
            check("rd_hold_valid",   32'(req_valid),  32'd1);
            check("rd_hold_bready",  32'(byte_ready), 32'd0);
            check("rd_hold_write",   32'(req_write),  32'd0);
            check("rd_hold_address", req_address,     32'h00402000);
            check("rd_hold_data",    req_data,        32'h0);
            if (c == 5) req_ready = 1'b1;
            tick();
        end
        check("rd_done_valid", 32'(req_valid),   32'd0);
        check("rd_frame_count", 32'(frame_count), 32'd2);

        // Unknown command, then a good read frame
        send_byte(8'h3C);
        check("cmd_err_pulse", 32'(err_cmd), 32'd1);
        check("cmd_no_req",    32'(req_valid), 32'd0);
        send_byte(R2_FRAME[0]);
        check("cmd_err_cleared", 32'(err_cmd), 32'd0);
        for (int i = 1; i < 6; i++) send_byte(R2_FRAME[i]);
        check("cmd_rd_valid",   32'(req_valid),  32'd1);
        check("cmd_rd_address", req_address,     32'h00403000);
        check("cmd_rd_data",    req_data,        32'h0);
        tick();
        check("cmd_frame_count", 32'(frame_count), 32'd3);
        check("cmd_err_count",   32'(n_cmd),       32'd1);

        // Bad checksum
        for (int i = 0; i < 9; i++) send_byte(W_FRAME[i]);
        send_byte(8'h00);
        check("csum_err_pulse", 32'(err_checksum), 32'd1);
        check("csum_no_req",    32'(req_valid),    32'd0);
        tick();
        check("csum_err_cleared", 32'(err_checksum), 32'd0);
        check("csum_no_req2",     32'(req_valid),    32'd0);
        check("csum_frame_count", 32'(frame_count),  32'd3);
        check("csum_err_count",   32'(n_csum),       32'd1);

        // Timeout after a partial frame (16 stalled cycles)
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h10);
        first_to = 0;
        to_base  = n_to;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (err_timeout && first_to == 0) first_to = k;
        end
        check("to_pulse_count", 32'(n_to - to_base), 32'd1);
        check("to_pulse_cycle", 32'(first_to),       32'd16);
        check("to_byte_ready",  32'(byte_ready),     32'd1);
        for (int i = 0; i < 6; i++) send_byte(R_FRAME[i]);
        check("to_rd_valid",   32'(req_valid), 32'd1);
        check("to_rd_address", req_address,    32'h00402000);
        check("to_rd_data",    req_data,       32'h0);
        tick();
        check("to_frame_count", 32'(frame_count), 32'd4);

        // Byte arriving exactly on the timeout cycle wins
        to_base = n_to;
        send_byte(R_FRAME[0]);
        for (int k = 0; k < 15; k++) tick();
        for (int i = 1; i < 6; i++) send_byte(R_FRAME[i]);
        check("edge_no_timeout", 32'(n_to - to_base), 32'd0);
        check("edge_rd_valid",   32'(req_valid),      32'd1);
        check("edge_rd_address", req_address,         32'h00402000);
        tick();
        check("edge_frame_count", 32'(frame_count), 32'd5);

        // Reset while a request is pending
        req_ready = 1'b0;
        for (int i = 0; i < 10; i++) send_byte(W_FRAME[i]);
        check("rstiss_pending", 32'(req_valid), 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("rstiss_req_valid",   32'(req_valid),   32'd0);
        check("rstiss_frame_count", 32'(frame_count), 32'd0);
        check("rstiss_byte_ready",  32'(byte_ready),  32'd1);
        check("rstiss_req_address", req_address,      32'h0);
        check("rstiss_req_data",    req_data,         32'h0);
        tick();
        check("rstiss_still_idle",  32'(req_valid),   32'd0);

        // Counter wrap: preload 16'hFFFF, then issue one more request
        force dut.frame_count = 16'hFFFF;
        #1;
        release dut.frame_count;
        req_ready = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(R_FRAME[i]);
        check("wrap_pending", 32'(req_valid),   32'd1);
        check("wrap_before",  32'(frame_count), 32'h0000FFFF);
        tick();
        check("wrap_after",   32'(frame_count), 32'd0);
        check("wrap_valid",   32'(req_valid),   32'd0);

        tick();
        check("err_exclusive", 32'(n_multi), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
